// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared width helpers, queue occupancy codes and RAM operation type
package sp_ram_pkg;
  localparam logic [1:0] Q_EMPTY = 2'd0;
  localparam logic [1:0] Q_ONE   = 2'd1;
  localparam logic [1:0] Q_FULL  = 2'd2;
  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} ram_op_e;
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int addr_w(input int depth);
    return clogb2(depth - 1);
  endfunction
  function automatic int lvl_w(input int depth);
    return clogb2(depth + 2);
  endfunction
endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// sp_ram_fifo_ctrl_if: producer, consumer and RAM-side signals of the FIFO controller
interface sp_ram_fifo_ctrl_if
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_en_n;
  logic              ram_we_n;
  logic [DATA_W-1:0] ram_dout;
  logic [LVL_W-1:0]  level;
  modport master (
    input  s_valid, s_data, m_ready, ram_dout,
    output s_ready, m_valid, m_data, ram_addr, ram_din, ram_en_n, ram_we_n, level
  );
  modport slave (
    output s_valid, s_data, m_ready, ram_dout,
    input  s_ready, m_valid, m_data, ram_addr, ram_din, ram_en_n, ram_we_n, level
  );
endinterface

// File: rtl/sp_fifo_out_queue.sv
// sp_fifo_out_queue: 2-entry registered FIFO that absorbs RAM read data ahead of the consumer
module sp_fifo_out_queue
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_o
);
  logic [1:0]        occ_q, occ_d, wr_idx;
  logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;
  logic              pop;
  // q0 is always the head; the incoming word lands in the slot left free after this cycle's pop
  always_comb begin
    pop    = pop_i && (occ_q != Q_EMPTY);
    wr_idx = occ_q - {1'b0, pop};
    occ_d  = wr_idx + {1'b0, push_i};
    q0_d   = (push_i && wr_idx == Q_EMPTY) ? din_i : (pop ? q1_q : q0_q);
    q1_d   = (push_i && wr_idx == Q_ONE) ? din_i : q1_q;
  end
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      occ_q <= Q_EMPTY;
      q0_q  <= '0;
      q1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      q0_q  <= q0_d;
      q1_q  <= q1_d;
    end
  end
  assign occ_o   = occ_q;
  assign valid_o = occ_q != Q_EMPTY;
  assign head_o  = valid_o ? q0_q : '0;
endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: FIFO controller over one single-port write-first RAM
// Reads take priority; a 2-entry output queue hides the 1-cycle RAM read latency.
module sp_ram_fifo_ctrl
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input logic                clka,
  input logic                rsta_n,
  sp_ram_fifo_ctrl_if.master bus
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  FULL_CNT = LVL_W'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              rd_inflight_q;
  logic [1:0]        q_occ;
  logic              q_valid;
  logic [DATA_W-1:0] q_head;
  logic              rd_grant, wr_grant, mem_full;
  ram_op_e           op;
  // a read is only issued when the queue is guaranteed a free slot on capture
  always_comb begin
    mem_full  = mem_cnt_q == FULL_CNT;
    rd_grant  = (mem_cnt_q != '0) && ((q_occ + {1'b0, rd_inflight_q}) < Q_FULL);
    wr_grant  = rsta_n && !rd_grant && bus.s_valid && !mem_full;
    op        = rd_grant ? OP_RD : (wr_grant ? OP_WR : OP_IDLE);
    wr_ptr_d  = !wr_grant ? wr_ptr_q : ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_W'(1));
    rd_ptr_d  = !rd_grant ? rd_ptr_q : ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + ADDR_W'(1));
    mem_cnt_d = mem_cnt_q + LVL_W'(wr_grant) - LVL_W'(rd_grant);
  end
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_grant;
    end
  end
  // ram_dout is only taken the cycle after a read, so write-first echoes are dropped
  sp_fifo_out_queue #(.DATA_W(DATA_W)) u_q (
    .clka    (clka),
    .rsta_n  (rsta_n),
    .push_i  (rd_inflight_q),
    .din_i   (bus.ram_dout),
    .pop_i   (bus.m_ready),
    .occ_o   (q_occ),
    .valid_o (q_valid),
    .head_o  (q_head)
  );
  assign bus.s_ready  = rsta_n && !rd_grant && !mem_full;
  assign bus.ram_en_n = op == OP_IDLE;
  assign bus.ram_we_n = op != OP_WR;
  assign bus.ram_addr = (op == OP_RD) ? rd_ptr_q : ((op == OP_WR) ? wr_ptr_q : '0);
  assign bus.ram_din  = bus.s_data;
  assign bus.m_valid  = q_valid;
  assign bus.m_data   = q_head;
  assign bus.level    = mem_cnt_q + LVL_W'(rd_inflight_q) + LVL_W'(q_occ);
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// tb_sp_ram_fifo_ctrl: directed vector table, reset/latency sequences and random traffic
// checked against a word-queue model of the FIFO contents and RAM address order.
module tb_sp_ram_fifo_ctrl;
  import sp_ram_pkg::*;
  localparam int D  = 4;
  localparam int DW = 32;
  logic clka   = 1'b0;
  logic rsta_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  sp_ram_fifo_ctrl_if #(.DATA_W(DW), .DEPTH(D)) b ();
  sp_ram_fifo_ctrl #(.DATA_W(DW), .DEPTH(D)) dut (.clka(clka), .rsta_n(rsta_n), .bus(b));
  always #5 clka = ~clka;
  logic [DW-1:0] mem [D];
  always @(posedge clka) begin
    if (!b.ram_en_n) begin
      if (!b.ram_we_n) begin
        mem[b.ram_addr] <= b.ram_din;
        b.ram_dout      <= b.ram_din;
      end else begin
        b.ram_dout <= mem[b.ram_addr];
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  logic [DW-1:0] mdl[$];
  int nwr = 0;
  int nrd = 0;
  int saw_full = 0;
  // every accepted word must come out once, in order; writes and reads walk addresses 0..D-1 cyclically
  always @(negedge clka) begin
    if (!rsta_n) begin
      mdl.delete();
      nwr = 0;
      nrd = 0;
    end else begin
      chk("level", 64'(b.level), 64'(mdl.size()));
      if (mdl.size() == D + 2) begin
        saw_full = 1;
        chk("full_s_ready", 64'(b.s_ready), 64'(0));
      end
      if (dut.rd_inflight_q && dut.q_occ == Q_FULL && !(b.m_valid && b.m_ready)) begin
        errors++;
        $display("FAIL q_overflow: capture into a full output queue at %0t", $time);
      end
      if (b.m_valid && b.m_ready) begin
        chk("pop_avail", 64'(mdl.size() != 0), 64'(1));
        if (mdl.size() != 0) chk("pop_data", 64'(b.m_data), 64'(mdl.pop_front()));
      end
      if (b.s_valid && b.s_ready) begin
        chk("wr_strobe", 64'({b.ram_en_n, b.ram_we_n}), 64'(0));
        chk("wr_addr", 64'(b.ram_addr), 64'(nwr % D));
        chk("wr_din", 64'(b.ram_din), 64'(b.s_data));
        mdl.push_back(b.s_data);
        nwr++;
      end else if (!b.ram_en_n) begin
        chk("rd_strobe", 64'(b.ram_we_n), 64'(1));
        chk("rd_addr", 64'(b.ram_addr), 64'(nrd % D));
        nrd++;
      end
    end
  end
  typedef struct {
    int sv; int sd; int mr;
    int sr; int mv; int md; int lvl; int en; int we; int addr;
  } vec_t;
  vec_t tbl [19];
  task automatic apply(input vec_t r, input int i);
    b.s_valid = r.sv[0];
    b.s_data  = r.sd;
    b.m_ready = r.mr[0];
    @(negedge clka);
    chk($sformatf("row%0d_s_ready", i), 64'(b.s_ready), 64'(r.sr));
    chk($sformatf("row%0d_m_valid", i), 64'(b.m_valid), 64'(r.mv));
    if (r.mv != 0) chk($sformatf("row%0d_m_data", i), 64'(b.m_data), 64'(r.md));
    chk($sformatf("row%0d_level", i), 64'(b.level), 64'(r.lvl));
    chk($sformatf("row%0d_ram_en_n", i), 64'(b.ram_en_n), 64'(r.en));
    if (r.en == 0) begin
      chk($sformatf("row%0d_ram_we_n", i), 64'(b.ram_we_n), 64'(r.we));
      chk($sformatf("row%0d_ram_addr", i), 64'(b.ram_addr), 64'(r.addr));
    end
    @(posedge clka);
    #1;
  endtask
  task automatic pulse_reset();
    b.s_valid = 1'b0;
    b.m_ready = 1'b0;
    #2 rsta_n = 1'b0;
    @(posedge clka);
    #3 rsta_n = 1'b1;
    @(posedge clka);
    #1;
  endtask
  task automatic drain(input string n);
    int k;
    k = 0;
    b.s_valid = 1'b0;
    b.m_ready = 1'b1;
    while (b.level != 0 && k < 100) begin
      @(posedge clka);
      #1;
      k++;
    end
    chk(n, 64'(b.level), 64'(0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    int sent;
    int cyc;
    logic acc;
    //         sv  sd     mr  sr mv md     lvl en we addr
    tbl[0]  = '{1, 'h11,  0,  1, 0, 0,     0,  0, 0, 0};
    tbl[1]  = '{1, 'h22,  0,  0, 0, 0,     1,  0, 1, 0};
    tbl[2]  = '{1, 'h22,  0,  1, 0, 0,     1,  0, 0, 1};
    tbl[3]  = '{1, 'h33,  0,  0, 1, 'h11,  2,  0, 1, 1};
    tbl[4]  = '{1, 'h33,  0,  1, 1, 'h11,  2,  0, 0, 2};
    tbl[5]  = '{1, 'h44,  0,  1, 1, 'h11,  3,  0, 0, 3};
    tbl[6]  = '{1, 'h55,  0,  1, 1, 'h11,  4,  0, 0, 0};
    tbl[7]  = '{1, 'h66,  0,  1, 1, 'h11,  5,  0, 0, 1};
    tbl[8]  = '{1, 'h77,  0,  0, 1, 'h11,  6,  1, 0, 0};
    tbl[9]  = '{1, 'h88,  0,  0, 1, 'h11,  6,  1, 0, 0};
    tbl[10] = '{0, 0,     1,  0, 1, 'h11,  6,  1, 0, 0};
    tbl[11] = '{0, 0,     1,  0, 1, 'h22,  5,  0, 1, 2};
    tbl[12] = '{0, 0,     1,  0, 0, 0,     4,  0, 1, 3};
    tbl[13] = '{0, 0,     1,  1, 1, 'h33,  4,  1, 0, 0};
    tbl[14] = '{0, 0,     1,  0, 1, 'h44,  3,  0, 1, 0};
    tbl[15] = '{0, 0,     1,  0, 0, 0,     2,  0, 1, 1};
    tbl[16] = '{0, 0,     1,  1, 1, 'h55,  2,  1, 0, 0};
    tbl[17] = '{0, 0,     1,  1, 1, 'h66,  1,  1, 0, 0};
    tbl[18] = '{0, 0,     0,  1, 0, 0,     0,  1, 0, 0};
    b.s_valid = 1'b1;
    b.s_data  = 32'hA5A5A5A5;
    b.m_ready = 1'b1;
    #2;
    chk("rst_s_ready", 64'(b.s_ready), 64'(0));
    chk("rst_m_valid", 64'(b.m_valid), 64'(0));
    chk("rst_ram_en_n", 64'(b.ram_en_n), 64'(1));
    chk("rst_ram_we_n", 64'(b.ram_we_n), 64'(1));
    chk("rst_ram_addr", 64'(b.ram_addr), 64'(0));
    chk("rst_level", 64'(b.level), 64'(0));
    chk("rst_m_data", 64'(b.m_data), 64'(0));
    b.s_valid = 1'b0;
    @(posedge clka);
    @(posedge clka);
    #3 rsta_n = 1'b1;
    @(posedge clka);
    #1;
    for (int i = 0; i < 19; i++) apply(tbl[i], i);
    // level 5 with a read in flight, then reset lands mid-cycle
    pulse_reset();
    for (int i = 0; i <= 10; i++) apply(tbl[i], i);
    b.s_valid = 1'b0;
    b.m_ready = 1'b0;
    @(negedge clka);
    chk("t6_read_issued", 64'({b.ram_en_n, b.ram_we_n}), 64'(1));
    @(posedge clka);
    #1;
    chk("t6_inflight", 64'(dut.rd_inflight_q), 64'(1));
    chk("t6_level_before", 64'(b.level), 64'(5));
    b.s_valid = 1'b1;
    b.s_data  = 32'hDEADBEEF;
    #2 rsta_n = 1'b0;
    #1;
    chk("t6_m_valid", 64'(b.m_valid), 64'(0));
    chk("t6_ram_en_n", 64'(b.ram_en_n), 64'(1));
    chk("t6_s_ready", 64'(b.s_ready), 64'(0));
    chk("t6_level", 64'(b.level), 64'(0));
    chk("t6_m_data", 64'(b.m_data), 64'(0));
    @(posedge clka);
    #3 rsta_n = 1'b1;
    @(negedge clka);
    chk("t5_ram_en_n", 64'(b.ram_en_n), 64'(0));
    chk("t5_ram_we_n", 64'(b.ram_we_n), 64'(0));
    chk("t5_ram_addr", 64'(b.ram_addr), 64'(0));
    chk("t5_ram_din", 64'(b.ram_din), 64'(32'hDEADBEEF));
    chk("t6_after_m_valid", 64'(b.m_valid), 64'(0));
    chk("t6_after_m_data", 64'(b.m_data), 64'(0));
    @(posedge clka);
    #1;
    b.s_valid = 1'b0;
    lat = 0;
    while (!b.m_valid && lat < 10) begin
      @(posedge clka);
      #1;
      lat++;
    end
    chk("t5_latency", 64'(lat), 64'(2));
    chk("t5_m_data", 64'(b.m_data), 64'(32'hDEADBEEF));
    drain("t5_drain");
    // simultaneous traffic: 32 words must pass in order at roughly one word per two cycles
    b.m_ready = 1'b1;
    b.s_valid = 1'b1;
    b.s_data  = $urandom;
    sent = 0;
    cyc  = 0;
    while (sent < 32 && cyc < 200) begin
      @(negedge clka);
      acc = b.s_valid && b.s_ready;
      @(posedge clka);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        b.s_data = $urandom;
      end
    end
    b.s_valid = 1'b0;
    chk("t3_sent", 64'(sent), 64'(32));
    chk("t3_rate", 64'(cyc <= 68), 64'(1));
    drain("t3_drain");
    // random traffic, alternating fill-biased and drain-biased phases
    b.s_valid = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clka);
      acc = b.s_valid && b.s_ready;
      @(posedge clka);
      #1;
      if (acc || !b.s_valid) begin
        b.s_valid = $urandom_range(0, 3) < (((k / 100) % 2 == 1) ? 1 : 3);
        b.s_data  = $urandom;
      end
      b.m_ready = $urandom_range(0, 3) < (((k / 100) % 2 == 1) ? 3 : 1);
    end
    drain("rand_drain");
    @(negedge clka);
    chk("rand_model_empty", 64'(mdl.size()), 64'(0));
    chk("rand_hit_full", 64'(saw_full), 64'(1));
    chk("end_m_valid", 64'(b.m_valid), 64'(0));
    chk("end_ram_en_n", 64'(b.ram_en_n), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
